// File: rtl/udma_i2c_pkg.sv
// rtl/udma_i2c_pkg.sv - shared types and helpers for the I2C bus engine
// Purpose: bus command codes, quarter-phase and FSM state encodings, and the
//          helper that picks the SDA value for a bit slot.
// Ports:   none (package)
package udma_i2c_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'b000,
        CMD_START = 3'b001,
        CMD_STOP  = 3'b010,
        CMD_WRITE = 3'b011,
        CMD_READ  = 3'b100,
        CMD_WAIT  = 3'b101
    } bus_cmd_e;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_e;

    typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_WAIT} state_e;

    localparam logic [3:0] LAST_SLOT = 4'd8;

    // Level the master puts on SDA in a bit slot (1 = release the line).
    // Slot 8 is the acknowledge slot: released on WRITE, ACK/NACK on READ.
    function automatic logic slot_bit(bus_cmd_e cmd, logic [7:0] data,
                                      logic nack, logic [3:0] slot);
        if (slot == LAST_SLOT)
            return (cmd == CMD_WRITE) ? 1'b1 : nack;
        else
            return (cmd == CMD_WRITE) ? data[3'd7 - slot[2:0]] : 1'b1;
    endfunction

endpackage

// File: rtl/udma_i2c_bus_engine_quarter_timer.sv
// rtl/udma_i2c_bus_engine_quarter_timer.sv - quarter-bit period counter
// Purpose: counts 0..i_div while running; o_tick marks the terminal cycle of a
//          quarter. i_freeze holds the count at 0 (SCL stretching).
// Ports:   clk_i, rst_i         clock, sync active-high reset
//          i_load               restart the count at 0
//          i_run                engine busy, counting enabled
//          i_freeze             hold count at 0, suppress tick
//          i_div [DIV_W]        terminal count (quarter = i_div+1 cycles)
//          o_tick               last cycle of the current quarter
module udma_i2c_quarter_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic             i_run,
    input  logic             i_freeze,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_run & ~i_freeze & (r_cnt == i_div);

    always_ff @(posedge clk_i) begin
        if (rst_i || i_load || !i_run || i_freeze || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/udma_i2c_bus_engine.sv
// rtl/udma_i2c_bus_engine.sv - bit/byte level I2C master bus engine
// Purpose: executes one START/STOP/WRITE/READ/WAIT command at a time, driving
//          open-drain SCL/SDA in quarter-bit phases, with clock stretching.
// Ports:   clk_i, rst_i                       clock, sync active-high reset
//          cmd_i, cmd_data_i, cmd_nack_i      command, write byte, read NACK
//          cmd_valid_i / cmd_ready_o          command handshake
//          clkdiv_i                           quarter period - 1, latched at accept
//          done_o, data_o, ack_o, busy_o      completion pulse and results
//          scl_i, sda_i                       pad inputs
//          scl_o, sda_o, scl_oe, sda_oe       open-drain pad controls
module udma_i2c_bus_engine
    import udma_i2c_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       cmd_i,
    input  logic [7:0]       cmd_data_i,
    input  logic             cmd_nack_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [DIV_W-1:0] clkdiv_i,
    output logic             done_o,
    output logic [7:0]       data_o,
    output logic             ack_o,
    output logic             busy_o,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_o,
    output logic             sda_o,
    output logic             scl_oe,
    output logic             sda_oe
);

    state_e           r_state;
    phase_e           r_phase;
    bus_cmd_e         r_cmd;
    logic [7:0]       r_data;
    logic             r_nack;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_slot;
    logic [7:0]       r_shift;
    logic             r_ackbit;
    logic             r_scl_oe;
    logic             r_sda_oe;
    logic             r_done;
    logic             r_ready;
    logic [7:0]       r_data_o;
    logic             r_ack_o;

    bus_cmd_e w_cmd;
    logic     w_accept;
    logic     w_run;
    logic     w_freeze;
    logic     w_tick;

    assign w_cmd    = bus_cmd_e'(cmd_i);
    assign w_accept = cmd_valid_i & r_ready;
    assign w_run    = (r_state != S_IDLE);
    // Only phases that release SCL wait for it; WAIT keeps SCL as it was.
    assign w_freeze = (r_phase == Q1) && (r_state != S_WAIT) && !scl_i;

    udma_i2c_quarter_timer #(.DIV_W(DIV_W)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_load   (w_accept),
        .i_run    (w_run),
        .i_freeze (w_freeze),
        .i_div    (r_div),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_phase  <= Q0;
            r_cmd    <= CMD_NONE;
            r_data   <= '0;
            r_nack   <= 1'b0;
            r_div    <= '0;
            r_slot   <= '0;
            r_shift  <= '0;
            r_ackbit <= 1'b0;
            r_scl_oe <= 1'b0;
            r_sda_oe <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
            r_data_o <= '0;
            r_ack_o  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_cmd   <= w_cmd;
                    r_data  <= cmd_data_i;
                    r_nack  <= cmd_nack_i;
                    r_div   <= clkdiv_i;
                    r_phase <= Q0;
                    r_slot  <= '0;
                    // Lines for q0 of the new command are set on the accept edge.
                    case (w_cmd)
                        CMD_START: begin
                            r_state  <= S_START;
                            r_sda_oe <= 1'b0;
                            r_ready  <= 1'b0;
                        end
                        CMD_STOP: begin
                            r_state  <= S_STOP;
                            r_sda_oe <= 1'b1;
                            r_ready  <= 1'b0;
                        end
                        CMD_WRITE, CMD_READ: begin
                            r_state  <= S_BIT;
                            r_scl_oe <= 1'b1;
                            r_sda_oe <= ~slot_bit(w_cmd, cmd_data_i, cmd_nack_i, 4'd0);
                            r_ready  <= 1'b0;
                        end
                        CMD_WAIT: begin
                            r_state <= S_WAIT;
                            r_ready <= 1'b0;
                        end
                        default: r_done <= 1'b1;
                    endcase
                end
            end else if (w_tick) begin
                r_phase <= phase_e'(r_phase + 2'd1);
                case (r_phase)
                    Q0: begin
                        if (r_state != S_WAIT)
                            r_scl_oe <= 1'b0;
                    end
                    Q1: begin
                        if (r_state == S_START)
                            r_sda_oe <= 1'b1;
                        else if (r_state == S_STOP)
                            r_sda_oe <= 1'b0;
                    end
                    Q2: begin
                        if (r_state == S_START || r_state == S_BIT)
                            r_scl_oe <= 1'b1;
                        // Last cycle of q2: SCL is still high, data is stable.
                        if (r_state == S_BIT) begin
                            if (r_slot == LAST_SLOT)
                                r_ackbit <= ~sda_i;
                            else
                                r_shift <= {r_shift[6:0], sda_i};
                        end
                    end
                    Q3: begin
                        if (r_state == S_BIT && r_slot != LAST_SLOT) begin
                            r_slot   <= r_slot + 4'd1;
                            r_sda_oe <= ~slot_bit(r_cmd, r_data, r_nack, r_slot + 4'd1);
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            if (r_cmd == CMD_WRITE)
                                r_ack_o <= r_ackbit;
                            if (r_cmd == CMD_READ)
                                r_data_o <= r_shift;
                        end
                    end
                endcase
            end
        end
    end

    assign cmd_ready_o = r_ready;
    assign busy_o      = ~r_ready;
    assign done_o      = r_done;
    assign data_o      = r_data_o;
    assign ack_o       = r_ack_o;
    assign scl_oe      = r_scl_oe;
    assign sda_oe      = r_sda_oe;
    assign scl_o       = 1'b0;
    assign sda_o       = 1'b0;

endmodule

// File: tb/tb_udma_i2c_bus_engine.sv
// tb/tb_udma_i2c_bus_engine.sv - self-checking bench for udma_i2c_bus_engine
module tb_udma_i2c_bus_engine;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  cmd_i = 3'd0;
    logic [7:0]  cmd_data_i = 8'd0;
    logic        cmd_nack_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [15:0] clkdiv_i = 16'd1;
    logic        done_o;
    logic [7:0]  data_o;
    logic        ack_o;
    logic        busy_o;
    logic        scl_i, sda_i, scl_o, sda_o, scl_oe, sda_oe;

    always #5 clk = ~clk;

    udma_i2c_bus_engine #(.DIV_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .cmd_i(cmd_i), .cmd_data_i(cmd_data_i),
        .cmd_nack_i(cmd_nack_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .clkdiv_i(clkdiv_i), .done_o(done_o), .data_o(data_o), .ack_o(ack_o),
        .busy_o(busy_o), .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
        .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    // One expected cycle of a command: master line controls, slave activity.
    typedef struct packed {
        logic       scl;
        logic       sda;
        logic       st;
        logic       pull;
        logic [3:0] slot;
    } ent_t;

    ent_t       sched[$];
    ent_t       cur;
    bit         cur_valid = 0, exp_done = 0, started = 0;
    bit         m_scl = 0, m_sda = 0, m_ack = 0, pend_ack = 0;
    logic [7:0] m_data = 8'd0, pend_data = 8'd0;
    int         pend_kind = 0, mdiv = 0;
    int         st_slot = -1, st_len = 0;
    logic [7:0] sl_byte = 8'd0;
    bit         sl_ack = 0;
    int         n_pass = 0, n_chk = 0;

    // Slave side of the wired-AND bus.
    assign scl_i = ~scl_oe & ~(cur_valid & cur.st);
    assign sda_i = ~sda_oe & ~(cur_valid & cur.pull);

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push_q(input int slot, input int q, input bit pull);
        ent_t e;
        int   ns;
        ns = (q == 1 && slot == st_slot) ? st_len : 0;
        e.scl = m_scl; e.sda = m_sda; e.pull = pull; e.slot = slot[3:0];
        e.st = 1'b1;
        repeat (ns) sched.push_back(e);
        e.st = 1'b0;
        repeat (mdiv + 1) sched.push_back(e);
    endtask

    // Model: on each accepted command lay out the whole expected waveform.
    always @(posedge clk) begin
        bit r, acc, nk;
        logic [2:0] c;
        logic [7:0] dd;
        int dv;
        r = rst_i; acc = cmd_valid_i && cmd_ready_o; c = cmd_i;
        dd = cmd_data_i; nk = cmd_nack_i; dv = int'(clkdiv_i);
        #1;
        if (r) begin
            started = 1; sched.delete(); cur_valid = 0; exp_done = 0;
            m_scl = 0; m_sda = 0; m_ack = 0; m_data = 8'd0; pend_kind = 0;
        end else begin
            exp_done = 0;
            if (acc) begin
                mdiv = dv; pend_kind = int'(c); pend_ack = sl_ack; pend_data = sl_byte;
                case (c)
                    3'd1: begin
                        m_sda = 0; push_q(0, 0, 0); m_scl = 0; push_q(0, 1, 0);
                        m_sda = 1; push_q(0, 2, 0); m_scl = 1; push_q(0, 3, 0);
                    end
                    3'd2: begin
                        m_sda = 1; push_q(0, 0, 0); m_scl = 0; push_q(0, 1, 0);
                        m_sda = 0; push_q(0, 2, 0); push_q(0, 3, 0);
                    end
                    3'd3, 3'd4: for (int s = 0; s < 9; s++) begin
                        bit b, p;
                        if (c == 3'd3) begin
                            b = (s < 8) ? dd[7-s] : 1'b1;
                            p = (s == 8) && sl_ack;
                        end else begin
                            b = (s < 8) ? 1'b1 : nk;
                            p = (s < 8) && !sl_byte[7-s];
                        end
                        m_scl = 1; m_sda = !b; push_q(s, 0, p);
                        m_scl = 0; push_q(s, 1, p); push_q(s, 2, p);
                        m_scl = 1; push_q(s, 3, p);
                    end
                    3'd5: for (int q = 0; q < 4; q++) push_q(0, q, 0);
                    default: exp_done = 1;
                endcase
            end
            if (sched.size() > 0) begin
                cur = sched.pop_front(); cur_valid = 1;
            end else if (cur_valid) begin
                cur_valid = 0; exp_done = 1;
                if (pend_kind == 3) m_ack = pend_ack;
                if (pend_kind == 4) m_data = pend_data;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("scl_oe", scl_oe, cur_valid ? cur.scl : m_scl);
            chk("sda_oe", sda_oe, cur_valid ? cur.sda : m_sda);
            chk("busy_o", busy_o, cur_valid);
            chk("cmd_ready_o", cmd_ready_o, !cur_valid);
            chk("done_o", done_o, exp_done);
            chk("data_o", data_o, m_data);
            chk("ack_o", ack_o, m_ack);
            chk("scl_o/sda_o", {scl_o, sda_o}, 0);
        end
    end

    // Bus monitor: START/STOP conditions and SDA captured at SCL rising edges.
    int       start_cnt = 0, stop_cnt = 0;
    bit       prev_scl = 1, prev_sda = 1;
    bit [8:0] cap = 9'd0;
    always @(negedge clk) begin
        if (scl_i && prev_scl) begin
            if (prev_sda && !sda_i) start_cnt++;
            if (!prev_sda && sda_i) stop_cnt++;
        end
        if (scl_i && !prev_scl) cap = {cap[7:0], sda_i};
        prev_scl = scl_i; prev_sda = sda_i;
    end

    task automatic issue(input logic [2:0] c, input logic [7:0] d, input bit nk,
                         input int dv, input int keep, input int newdiv, output int lat);
        @(posedge clk); #1;
        cmd_i = c; cmd_data_i = d; cmd_nack_i = nk; clkdiv_i = dv[15:0]; cmd_valid_i = 1;
        @(posedge clk); #1;
        clkdiv_i = newdiv[15:0];
        if (keep == 0) cmd_valid_i = 0;
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == keep) cmd_valid_i = 0;
            if (done_o) break;
        end
        cmd_valid_i = 0;
    endtask

    initial begin
        int lat, s0, dn;
        repeat (2) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        chk("rst ready", cmd_ready_o, 1); chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0); chk("rst data", data_o, 0);
        chk("rst ack", ack_o, 0); chk("rst oe", {scl_oe, sda_oe}, 0);

        // Reset in slot 4 of a READ: abort, lines released, no done.
        sl_byte = 8'h96;
        @(posedge clk); #1;
        cmd_i = 3'd4; cmd_nack_i = 0; clkdiv_i = 16'd1; cmd_valid_i = 1;
        @(posedge clk); #1 cmd_valid_i = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            if (cur_valid && cur.slot == 4'd4) break;
        end
        chk("reached slot4", cur_valid ? int'(cur.slot) : -1, 4);
        rst_i = 1;
        @(posedge clk); #1 rst_i = 0;
        @(negedge clk);
        chk("abort oe", {scl_oe, sda_oe}, 0); chk("abort ready", cmd_ready_o, 1);
        chk("abort done", done_o, 0); chk("abort data", data_o, 0);
        dn = 0;
        repeat (100) begin @(negedge clk); if (done_o) dn++; end
        chk("abort no done", dn, 0);

        // START from a free bus.
        s0 = start_cnt;
        issue(3'd1, 8'd0, 0, 1, 0, 1, lat);
        chk("start latency", lat, 9);
        chk("start cond", start_cnt - s0, 1);
        chk("start lines", {scl_oe, sda_oe}, 2'b11);

        issue(3'd5, 8'd0, 0, 2, 0, 2, lat);
        chk("wait div2 latency", lat, 13);
        issue(3'd5, 8'd0, 0, 0, 0, 0, lat);
        chk("wait div0 latency", lat, 5);

        // WRITE 0xA5 with slave ACK; divider changed mid-command.
        sl_ack = 1;
        issue(3'd3, 8'hA5, 0, 1, 0, 7, lat);
        chk("write latency", lat, 73);
        chk("write bits", cap, 9'h14A);
        chk("write ack", ack_o, 1);

        // READ 0x3C with NACK; valid kept high while busy.
        sl_ack = 0; sl_byte = 8'h3C;
        issue(3'd4, 8'd0, 1, 1, 10, 1, lat);
        chk("read latency", lat, 73);
        chk("read data", data_o, 8'h3C);
        chk("read nack bit", cap[0], 1);

        // WRITE 0xFF, slave stretches SCL 20 cycles in slot 3 q1, no ACK.
        st_slot = 3; st_len = 20;
        issue(3'd3, 8'hFF, 0, 1, 0, 1, lat);
        st_slot = -1; st_len = 0;
        chk("stretch latency", lat, 93);
        chk("stretch ack", ack_o, 0);

        // STOP then NOP.
        s0 = stop_cnt;
        issue(3'd2, 8'd0, 0, 1, 0, 1, lat);
        chk("stop latency", lat, 9);
        chk("stop cond", stop_cnt - s0, 1);
        chk("stop lines", {scl_oe, sda_oe}, 0);
        issue(3'd0, 8'd0, 0, 1, 0, 1, lat);
        chk("nop latency", lat, 1);
        chk("nop lines", {scl_oe, sda_oe}, 0);
        chk("nop data held", data_o, 8'h3C);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
